// File: rtl/sys_pkg.sv
// Shared definitions for the hourly traffic memory subsystem: bus op codes,
// table geometry and the hour-pointer wrap helper.
package sys_pkg;

  localparam int HOURS  = 24;
  localparam int CNT_W  = 15;
  localparam int RANK_W = 5;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    WRITE = 2'b01
  } op_t;

  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOURS - 1)) ? '0 : h + 1'b1;
  endfunction

endpackage

// File: rtl/traffic_mem_sched_sat_counter.sv
// Saturating up-counter. A clear coinciding with an increment restarts the
// count at 1, so a pulse arriving during a clear is not lost.
module sat_counter #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {{(W-1){1'b0}}, inc_i};
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments for state; blocking here would race other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_mem_sched.sv
// Hourly traffic sequencer: counts vehicles, commits each hour to memory (OP1)
// and writes back ranking results (OP2) after the day completes.
module traffic_mem_sched
  import sys_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HOUR_TICK,
  input  logic             VEHICLE_IN,
  input  logic             RANK_DONE,
  output logic [HOUR_W-1:0] HOUR,
  output logic [CNT_W-1:0] ACCUM_DATA1,
  output op_t              OP1,
  output op_t              OP2,
  output logic             RANK_REQ,
  output logic             RANK_OVERRUN
);

  typedef enum logic [1:0] {
    ACCUM,
    COMMIT,
    RANK_WB
  } state_t;

  state_t            state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              rank_req_q, rank_req_d;
  logic              overrun_q, overrun_d;
  logic              tick_pend_q, tick_pend_d;
  logic              done_pend_q, done_pend_d;
  logic              done_eff;

  // A done pulse only counts while a request is outstanding.
  assign done_eff = done_pend_q | (RANK_DONE & rank_req_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ACCUM;
      hour_q      <= '0;
      rank_req_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tick_pend_q <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      rank_req_q  <= rank_req_d;
      overrun_q   <= overrun_d;
      tick_pend_q <= tick_pend_d;
      done_pend_q <= done_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    rank_req_d  = rank_req_q;
    overrun_d   = overrun_q;
    tick_pend_d = tick_pend_q;
    done_pend_d = done_pend_q;
    unique case (state_q)
      ACCUM: begin
        if (HOUR_TICK) begin
          state_d     = COMMIT;
          done_pend_d = done_eff;
        end else if (done_eff) begin
          state_d = RANK_WB;
        end
      end
      COMMIT: begin
        hour_d      = next_hour(hour_q);
        tick_pend_d = 1'b0;
        done_pend_d = done_eff;
        if (hour_q == HOUR_W'(HOURS - 1)) begin
          if (rank_req_q) overrun_d  = 1'b1;
          else            rank_req_d = 1'b1;
        end
        state_d = done_eff ? RANK_WB : ACCUM;
      end
      RANK_WB: begin
        rank_req_d  = 1'b0;
        done_pend_d = 1'b0;
        tick_pend_d = tick_pend_q | HOUR_TICK;
        state_d     = (tick_pend_q | HOUR_TICK) ? COMMIT : ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    OP1 = NOP;
    OP2 = NOP;
    unique case (state_q)
      COMMIT:  OP1 = WRITE;
      RANK_WB: OP2 = WRITE;
      default: ;
    endcase
  end

  // The commit cycle restarts the count with that cycle's own pulse.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc_i (VEHICLE_IN),
    .clr_i (state_q == COMMIT),
    .cnt_o (ACCUM_DATA1)
  );

  assign HOUR         = hour_q;
  assign RANK_REQ     = rank_req_q;
  assign RANK_OVERRUN = overrun_q;

endmodule

// File: tb/tb_traffic_mem_sched.sv
// Bench for traffic_mem_sched: table vectors, directed corner sequences and a
// randomized run against an event-level reference model.
module tb_traffic_mem_sched;
  import sys_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              HOUR_TICK, VEHICLE_IN, RANK_DONE;
  logic [HOUR_W-1:0] HOUR;
  logic [CNT_W-1:0]  ACCUM_DATA1;
  op_t               OP1, OP2;
  logic              RANK_REQ, RANK_OVERRUN;

  traffic_mem_sched dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .HOUR_TICK    (HOUR_TICK),
    .VEHICLE_IN   (VEHICLE_IN),
    .RANK_DONE    (RANK_DONE),
    .HOUR         (HOUR),
    .ACCUM_DATA1  (ACCUM_DATA1),
    .OP1          (OP1),
    .OP2          (OP2),
    .RANK_REQ     (RANK_REQ),
    .RANK_OVERRUN (RANK_OVERRUN)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic tick;
    logic veh;
    logic done;
    logic op1w;
    logic op2w;
    int   hour;
    int   cnt;
    logic req;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic t, input logic v, input logic d);
    HOUR_TICK  = t;
    VEHICLE_IN = v;
    RANK_DONE  = d;
    @(posedge CLK);
    #1;
    HOUR_TICK  = 1'b0;
    VEHICLE_IN = 1'b0;
    RANK_DONE  = 1'b0;
  endtask

  task automatic do_reset();
    RST_N      = 1'b0;
    HOUR_TICK  = 1'b0;
    VEHICLE_IN = 1'b0;
    RANK_DONE  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic hour_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reference model: every tick schedules a commit, every accepted done
  // schedules a write-back; one op is issued per cycle, commits first.
  int m_hour, m_cnt;
  bit m_req, m_ovr;
  int m_op;            // 0 idle, 1 commit issuing, 2 write-back issuing
  bit m_want_commit, m_want_wb;

  task automatic m_reset();
    m_hour = 0; m_cnt = 0; m_req = 0; m_ovr = 0;
    m_op = 0; m_want_commit = 0; m_want_wb = 0;
  endtask

  task automatic m_step(input bit t, input bit v, input bit d);
    bit req_before;
    req_before = m_req;
    if (m_op == 1) begin
      if (m_hour == HOURS - 1) begin
        if (m_req) m_ovr = 1;
        else       m_req = 1;
      end
      m_hour = (m_hour + 1) % HOURS;
      m_cnt  = v;
    end else if (v && m_cnt < (1 << CNT_W) - 1) begin
      m_cnt++;
    end
    if (m_op == 2) m_req = 0;
    if (t && m_op != 1) m_want_commit = 1;
    if (d && req_before && m_op != 2) m_want_wb = 1;
    if (m_want_commit) begin
      m_op = 1; m_want_commit = 0;
    end else if (m_want_wb) begin
      m_op = 2; m_want_wb = 0;
    end else begin
      m_op = 0;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [25:0] act, exp;
    int last_tick;
    bit t, v, d;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0};

    do_reset();
    check("reset hour", HOUR, 0);
    check("reset cnt", ACCUM_DATA1, 0);
    check("reset op1", OP1, NOP);
    check("reset op2", OP2, NOP);
    check("reset req", RANK_REQ, 0);
    check("reset ovr", RANK_OVERRUN, 0);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].tick, vecs[i].veh, vecs[i].done);
      check($sformatf("vec%0d op1", i), OP1 == WRITE, vecs[i].op1w);
      check($sformatf("vec%0d op2", i), OP2 == WRITE, vecs[i].op2w);
      check($sformatf("vec%0d hour", i), HOUR, vecs[i].hour);
      check($sformatf("vec%0d cnt", i), ACCUM_DATA1, vecs[i].cnt);
      check($sformatf("vec%0d req", i), RANK_REQ, vecs[i].req);
    end

    // Saturation at 32767.
    repeat (40000) cyc(1'b0, 1'b1, 1'b0);
    check("sat hold", ACCUM_DATA1, 32767);
    cyc(1'b1, 1'b1, 1'b0);
    check("sat commit op1", OP1, WRITE);
    check("sat commit cnt", ACCUM_DATA1, 32767);
    cyc(1'b0, 1'b0, 1'b0);
    check("sat next hour", HOUR, 3);
    check("sat cleared", ACCUM_DATA1, 0);

    // Full day, wrap, request, then delayed done.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k == 23) check("day hour23", HOUR, 23);
      cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("day op1 %0d", k), OP1, WRITE);
      check($sformatf("day req low %0d", k), RANK_REQ, 0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check("day wrap hour", HOUR, 0);
    check("day req rise", RANK_REQ, 1);
    repeat (9) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("wb op2", OP2, WRITE);
    check("wb op1", OP1, NOP);
    check("wb req still", RANK_REQ, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("wb op2 done", OP2, NOP);
    check("wb req clear", RANK_REQ, 0);

    // Done coincident with tick: commit first, write-back next.
    hour_ticks(24);
    check("coin req", RANK_REQ, 1);
    check("coin ovr", RANK_OVERRUN, 0);
    cyc(1'b1, 1'b0, 1'b1);
    check("coin op1", OP1, WRITE);
    check("coin op2 idle", OP2, NOP);
    cyc(1'b0, 1'b0, 1'b0);
    check("coin op1 idle", OP1, NOP);
    check("coin op2", OP2, WRITE);
    cyc(1'b0, 1'b0, 1'b0);
    check("coin op2 end", OP2, NOP);
    check("coin req clear", RANK_REQ, 0);
    check("coin hour", HOUR, 1);

    // Tick during write-back; vehicle during commit belongs to the new hour.
    hour_ticks(23);
    check("twb req", RANK_REQ, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("twb op2", OP2, WRITE);
    cyc(1'b1, 1'b0, 1'b0);
    check("twb op1", OP1, WRITE);
    check("twb op2 idle", OP2, NOP);
    cyc(1'b0, 1'b1, 1'b0);
    check("twb hour", HOUR, 1);
    check("twb cnt", ACCUM_DATA1, 1);
    check("twb req clear", RANK_REQ, 0);

    // Overrun: two days without done.
    hour_ticks(23);
    check("ovr first req", RANK_REQ, 1);
    check("ovr not yet", RANK_OVERRUN, 0);
    hour_ticks(24);
    check("ovr set", RANK_OVERRUN, 1);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    check("ovr sticky", RANK_OVERRUN, 1);
    check("ovr cnt", ACCUM_DATA1, 5);
    #2 RST_N = 1'b0;
    #1;
    check("async hour", HOUR, 0);
    check("async cnt", ACCUM_DATA1, 0);
    check("async req", RANK_REQ, 0);
    check("async ovr", RANK_OVERRUN, 0);
    check("async op1", OP1, NOP);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("commit before rst", OP1, WRITE);
    #2 RST_N = 1'b0;
    #1;
    check("async op1 mid", OP1, NOP);
    check("async hour mid", HOUR, 0);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    last_tick = -10;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        m_reset();
        last_tick = i - 10;
      end
      t = (i - last_tick >= 2) && ($urandom_range(3) == 0);
      if (t) last_tick = i;
      v = $urandom_range(1);
      d = m_req ? ($urandom_range(29) == 0) : ($urandom_range(49) == 0);
      cyc(t, v, d);
      m_step(t, v, d);
      act = {OP1, OP2, HOUR, ACCUM_DATA1, RANK_REQ, RANK_OVERRUN};
      exp = {(m_op == 1) ? 2'b01 : 2'b00, (m_op == 2) ? 2'b01 : 2'b00,
             HOUR_W'(m_hour), CNT_W'(m_cnt), m_req, m_ovr};
      check($sformatf("rnd cycle %0d", i), {6'd0, act}, {6'd0, exp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
